req_latch_arbiter: RTL and testbench

- Upstream stage of the 8-to-3 encoder.
- Captures rising edges on 8 request lines into a pending register and selects one pending request at a time.
- Presents the selection as a strictly one-hot 8-bit grant vector with a valid/ready handshake.
- The grant vector drives the encoder's 8-bit input directly. Because the grant is one-hot, the encoder's OR-based code is always unambiguous.

---
 rtl/req_latch_arbiter.sv | 152 +++++++++++++++
 tb/tb_req_latch_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/req_latch_arbiter.sv
// Request edge latch and one-hot grant arbiter feeding the 8-to-3 encoder.
// Define ROUND_ROBIN_EN for round-robin selection; default is fixed highest-index priority.
module req_latch_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  input  logic         gnt_ready,
  output logic [N-1:0] pend,
  output logic         ovf,
  input  logic         clr_ovf
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   req_q;
  logic [N-1:0]   rise;
  logic [N-1:0]   clear;
  logic [N-1:0]   pend_next;
  logic [N-1:0]   winner;
  logic [N-1:0]   gnt_next;
  logic           gnt_valid_next;
  logic           ovf_next;
  logic           handshake;

  assign rise      = req & ~req_q;
  assign handshake = gnt_valid & gnt_ready;
  assign clear     = handshake ? gnt : '0;

  // A rise on the bit being retired re-arms it rather than counting as overflow.
  assign pend_next = (pend & ~clear) | rise;
  assign ovf_next  = (|(rise & pend & ~clear)) | (ovf & ~clr_ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      req_q <= req;
      pend  <= pend_next;
      ovf   <= ovf_next;
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] gnt_idx;
  logic             rr_found;

  // Search starts just above the last granted index; offset N wraps back to rr_ptr itself.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      rr_idx = rr_ptr + IDX_W'(k);
      if (!rr_found && pend[rr_idx]) begin
        winner[rr_idx] = 1'b1;
        rr_found       = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= IDX_W'(N - 1);
    end else if (handshake) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  // Ascending scan lets the highest pending index overwrite lower ones.
  always_comb begin
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      gnt_valid <= gnt_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    gnt_next       = gnt;
    gnt_valid_next = gnt_valid;
    case (state)
      IDLE: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        if (|pend) begin
          gnt_next       = winner;
          gnt_valid_next = 1'b1;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        gnt_next       = '0;
        gnt_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  // The encoder downstream relies on these holding at all times.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
    gnt_valid |-> ($onehot(gnt) && ((gnt & pend) != '0)));
  a_gnt_idle_zero: assert property (@(posedge clk) disable iff (rst)
    !gnt_valid |-> (gnt == '0));
  a_gnt_stable: assert property (@(posedge clk) disable iff (rst)
    (gnt_valid && !gnt_ready) |=> (gnt_valid && $stable(gnt)));

endmodule

// File: tb/tb_req_latch_arbiter.sv
// Randomized bench for req_latch_arbiter against a set/queue-level reference model.
// Honours ROUND_ROBIN_EN the same way the design does.
module tb_req_latch_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [7:0] pend;
  logic       ovf;
  logic       clr_ovf;

  int n_compared;
  int n_mismatched;

  // Reference model state: pending set, currently granted index (-1 none), sticky flag.
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  int       m_cur;
  int       m_rr;
  bit       m_ovf;
  bit [7:0] drive_req;

  req_latch_arbiter #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .pend      (pend),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int pickWinner(input bit [7:0] p);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (m_rr + k) % 8;
      if (p[idx]) return idx;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (p[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    m_pend = '0;
    m_prev = '0;
    m_cur  = -1;
    m_rr   = 7;
    m_ovf  = 1'b0;
  endtask

  task automatic modelStep();
    bit [7:0] old_pend;
    bit       hs;
    bit       set_ovf;
    bit       r;
    if (rst) begin
      modelReset();
      return;
    end
    old_pend = m_pend;
    hs       = (m_cur >= 0) && gnt_ready;
    set_ovf  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = req[i] && !m_prev[i];
      if (hs && m_cur == i) m_pend[i] = 1'b0;
      if (r && old_pend[i] && !(hs && m_cur == i)) set_ovf = 1'b1;
      if (r) m_pend[i] = 1'b1;
    end
    if (m_cur >= 0) begin
      if (gnt_ready) begin
        m_rr  = m_cur;
        m_cur = -1;
      end
    end else if (old_pend != 0) begin
      m_cur = pickWinner(old_pend);
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_prev = req;
  endtask

  task automatic checkAll(input string phase);
    logic [7:0] exp_gnt;
    exp_gnt = '0;
    if (m_cur >= 0) exp_gnt[m_cur] = 1'b1;
    checkOutput({phase, ".gnt"}, gnt, exp_gnt);
    checkOutput({phase, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, (m_cur >= 0)});
    checkOutput({phase, ".pend"}, pend, m_pend);
    checkOutput({phase, ".ovf"}, {7'b0, ovf}, {7'b0, m_ovf});
    checkOutput({phase, ".onehot"}, {7'b0, ($countones(gnt) <= 1)}, 8'h01);
  endtask

  // Drive inputs, let one rising edge pass, then check on the falling edge.
  task automatic applyStimulus(input string phase, input logic [7:0] r, input logic rdy,
                               input logic co, input logic rs);
    req       = r;
    gnt_ready = rdy;
    clr_ovf   = co;
    rst       = rs;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll(phase);
  endtask

  // Raise reset between edges and confirm the outputs drop without a clock.
  task automatic asyncReset(input string phase);
    #2;
    rst = 1'b1;
    #1;
    checkOutput({phase, ".gnt"}, gnt, 8'h00);
    checkOutput({phase, ".gnt_valid"}, {7'b0, gnt_valid}, 8'h00);
    checkOutput({phase, ".pend"}, pend, 8'h00);
    checkOutput({phase, ".ovf"}, {7'b0, ovf}, 8'h00);
    modelReset();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    req       = '0;
    gnt_ready = 1'b0;
    clr_ovf   = 1'b0;
    drive_req = '0;
    modelReset();
    @(negedge clk);
    checkAll("reset");
    applyStimulus("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus("release", 8'h00, 1'b0, 1'b0, 1'b0);

    // Single request on bit 3 through a full handshake.
    applyStimulus("b3_edge", 8'h08, 1'b0, 1'b0, 1'b0);
    applyStimulus("b3_grant", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("b3_hs", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("b3_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Two simultaneous requests with the consumer always ready.
    applyStimulus("pair_edge", 8'h81, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("pair_drain", 8'h00, 1'b1, 1'b0, 1'b0);

    // Duplicate request on a held grant sets overflow, then clear it.
    applyStimulus("ovf_edge", 8'h04, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_grant", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_dup", 8'h04, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_clr", 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus("ovf_after", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("ovf_hs", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("ovf_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Fresh rise on the bit being handshaken re-arms it without overflow.
    applyStimulus("rearm_edge", 8'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus("rearm_grant", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("rearm_hs", 8'h20, 1'b1, 1'b0, 1'b0);
    applyStimulus("rearm_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("rearm_hs2", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("rearm_done", 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with sparse toggles and occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      drive_req = drive_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 249) == 0) begin
        asyncReset("rand_arst");
        applyStimulus("rand_rst", drive_req, 1'b0, 1'b0, 1'b1);
      end else begin
        applyStimulus("rand", drive_req, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0), 1'b0);
      end
    end

    // Reset mid-grant with four lines pending; held lines re-pend after release.
    applyStimulus("arst_quiet", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("arst_quiet", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("arst_quiet", 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus("arst_edge", 8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus("arst_grant", 8'hF0, 1'b0, 1'b0, 1'b0);
    asyncReset("arst_mid");
    applyStimulus("arst_hold", 8'hF0, 1'b0, 1'b0, 1'b1);
    applyStimulus("arst_repend", 8'hF0, 1'b0, 1'b0, 1'b0);
    applyStimulus("arst_regrant", 8'hF0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
